bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Write-port scheduler and initializer for the branch predictor's pattern/history tables.
- Queues resolved-branch updates from EX in a small FIFO and drains them to the table's single write port one per cycle, honouring a hold from the table owner.
- After reset, or on a flush request, runs a sweep that rewrites every table entry to a known initial value.
- Reports busy while sweeping, so fetch treats predictions as not-taken.

Parameters:
- IDX_W, 6: table index width.
- ENTRIES, 2**IDX_W: number of table entries swept.
- DATA_W, 2: entry width (2-bit counter state).
- INIT_VAL, 2'b01: value written by the sweep (weakly not-taken).
- DEPTH, 4: update FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- upd_valid  in  1  update request from EX.
- upd_ready  out  1  update accepted when upd_valid&upd_ready.
- upd_idx  in  IDX_W  entry to write.
- upd_data  in  DATA_W  new entry value.
- upd_mispred  in  1  update corresponds to a misprediction (statistics only).
- flush_req  in  1  single-cycle pulse: discard queue, re-initialize table.
- hold  in  1  table write port unavailable this cycle.
- tbl_we  out  1  table write enable.
- tbl_widx  out  IDX_W  table write index.
- tbl_wdata  out  DATA_W  table write data.
- busy  out  1  sweep in progress.
- fifo_count  out  $clog2(DEPTH+1)  queued updates.
- perf_upd_cnt  out  32  accepted updates (optional feature).
- perf_mispred_cnt  out  32  accepted mispredicted updates (optional feature).

Behaviour:
- State machine has two states, SWEEP and RUN. State, sweep pointer, FIFO and counters are all registers.
- Reset values: state=SWEEP, ptr=0, FIFO empty, fifo_count=0, busy=1, tbl_we=1, tbl_widx=0, tbl_wdata=INIT_VAL, perf counters=0.
- Outputs are combinational from registered state and FIFO head. They do not depend on upd_valid, so there is no input-to-output combinational path.
- SWEEP:
  - tbl_we=1, tbl_widx=ptr, tbl_wdata=INIT_VAL. hold is ignored; the sweep owns the port.
  - ptr increments every cycle. At ptr==ENTRIES-1: write, then next state=RUN, ptr=0.
  - The sweep takes exactly ENTRIES cycles. busy=1 throughout.
  - upd_ready=1; accepted updates are discarded (not queued, not counted).
- RUN:
  - busy=0.
  - upd_ready = (fifo_count != DEPTH). It does not depend on a same-cycle pop.
  - Accepted update is pushed at the tail. It is visible at the head the next cycle, so minimum accept-to-write latency is 1 cycle.
  - tbl_we = (fifo_count!=0) & ~hold, with tbl_widx/tbl_wdata taken from the head. The head pops in any cycle where tbl_we=1.
  - Simultaneous push and pop: count unchanged; order preserved (FIFO, no reordering).
  - No coalescing: duplicate idx entries are written in order, last write wins.
  - hold=1 with a non-empty FIFO: head is held. The FIFO fills and upd_ready drops at DEPTH.
- flush_req:
  - In RUN: FIFO emptied immediately. Any same-cycle push is dropped and the same-cycle pop is suppressed (tbl_we still shows the head that cycle but is not counted as a pop). Next state=SWEEP, ptr=0.
  - In SWEEP: ptr restarts at 0 next cycle.
- Pointers wrap modulo DEPTH; the count distinguishes full from empty.
- Asynchronous rst mid-sweep or mid-drain returns everything to reset values immediately. No partial writes are replayed.

Optional Feature:
- Macro: BP_UPD_SCHED_PERF_EN.
- When defined:
  - perf_upd_cnt increments on each RUN-state handshake not coincident with flush_req.
  - perf_mispred_cnt increments on the same condition when upd_mispred=1.
  - Both are 32-bit and wrap. Cleared only by rst, not by flush.
- When undefined: both ports are present and tied to 0, and no counter flops exist.

Test Plan:
- Reset release, ENTRIES=64: tbl_we=1 with tbl_widx 0..63 on 64 consecutive cycles, all tbl_wdata=2'b01. busy falls on cycle 64; first RUN cycle has tbl_we=0, fifo_count=0.
- RUN, hold=0: push idx=5/data=3 at cycle t -> tbl_we=1, widx=5, wdata=3 at t+1. Back-to-back pushes idx 1,2,3 -> writes 1,2,3 on consecutive cycles, fifo_count never exceeds 1.
- hold=1, push 6 updates with upd_valid held -> first 4 accepted, upd_ready=0 with fifo_count=4. Release hold -> writes in order, one per cycle. Remaining 2 accepted as space frees; upd_ready never rises in the same cycle the FIFO is full.
- fifo_count=3 with a flush_req coincident with a push -> push dropped, fifo_count=0 next cycle, busy=1, sweep restarts at index 0. A second flush 10 cycles into the sweep restarts at 0, giving 74 busy cycles in total.
- Async rst asserted mid-drain (fifo_count=2) -> outputs reach reset values without a clock edge; after release, a full 64-cycle sweep runs and no stale queued writes appear.
- With BP_UPD_SCHED_PERF_EN: 10 accepted updates, 3 with upd_mispred=1, plus 2 pushes during a sweep -> perf_upd_cnt=10, perf_mispred_cnt=3. Without the macro both read 0.

Source files
------------

// File: rtl/bp_update_sched_if.sv
`default_nettype none
// =============================================================================
// Module      : bp_update_sched_if
// Description : Update/flush/table-write bundle between EX, the predictor
//               table and the bp_update_sched write-port scheduler.
// Revision    : 1.0 - initial release
// =============================================================================
interface bp_update_sched_if #(
    parameter int IDX_W  = 6,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              upd_valid;
    logic              upd_ready;
    logic [IDX_W-1:0]  upd_idx;
    logic [DATA_W-1:0] upd_data;
    logic              upd_mispred;
    logic              flush_req;
    logic              hold;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_widx;
    logic [DATA_W-1:0] tbl_wdata;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       perf_upd_cnt;
    logic [31:0]       perf_mispred_cnt;

    modport master (
        output upd_valid, upd_idx, upd_data, upd_mispred, flush_req, hold,
        input  upd_ready, tbl_we, tbl_widx, tbl_wdata, busy, fifo_count,
               perf_upd_cnt, perf_mispred_cnt
    );

    modport slave (
        input  upd_valid, upd_idx, upd_data, upd_mispred, flush_req, hold,
        output upd_ready, tbl_we, tbl_widx, tbl_wdata, busy, fifo_count,
               perf_upd_cnt, perf_mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bp_update_sched.sv
`default_nettype none
// =============================================================================
// Module      : bp_update_sched
// Description : Branch-predictor table write-port scheduler. Sweeps the table
//               to INIT_VAL after reset/flush, then drains queued EX updates
//               one per cycle. Optional perf counters: BP_UPD_SCHED_PERF_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module bp_update_sched #(
    parameter int                IDX_W    = 6,
    parameter int                ENTRIES  = 2**IDX_W,
    parameter int                DATA_W   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(2'b01),
    parameter int                DEPTH    = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bp_update_sched_if.slave bus
);
    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W  = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_q_idx  [DEPTH];
    logic [DATA_W-1:0]  r_q_data [DEPTH];

    logic               w_we, w_busy, w_ready, w_push, w_pop, w_flush_run;
    logic [IDX_W-1:0]   w_widx;
    logic [DATA_W-1:0]  w_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        w_widx      = r_q_idx[r_rd_ptr];
        w_wdata     = r_q_data[r_rd_ptr];
        w_busy      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            SWEEP: begin
                // The sweep owns the write port; hold is deliberately ignored.
                w_we    = 1'b1;
                w_widx  = r_ptr;
                w_wdata = INIT_VAL;
                w_busy  = 1'b1;
                w_ready = 1'b1;
                if (bus.flush_req) begin
                    w_ptr_nxt = '0;
                end else if (r_ptr == c_LAST) begin
                    w_state_nxt = RUN;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + IDX_W'(1);
                end
            end
            RUN: begin
                w_ready = (r_count != c_FULL);
                w_we    = (r_count != '0) && !bus.hold;
                if (bus.flush_req) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = SWEEP;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Flush in RUN wins over any same-cycle push or pop.
    assign w_flush_run = (r_state == RUN) && bus.flush_req;
    assign w_push      = (r_state == RUN) && bus.upd_valid && w_ready && !bus.flush_req;
    assign w_pop       = (r_state == RUN) && w_we && !bus.flush_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush_run) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + {{(CNT_W-1){1'b0}}, w_push}
                               - {{(CNT_W-1){1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr]  <= bus.upd_idx;
            r_q_data[r_wr_ptr] <= bus.upd_data;
        end
    end

    assign bus.tbl_we     = w_we;
    assign bus.tbl_widx   = w_widx;
    assign bus.tbl_wdata  = w_wdata;
    assign bus.busy       = w_busy;
    assign bus.upd_ready  = w_ready;
    assign bus.fifo_count = r_count;

`ifdef BP_UPD_SCHED_PERF_EN
    logic [31:0] r_perf_upd, r_perf_mis;

    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_upd <= '0;
            r_perf_mis <= '0;
        end else if (w_push) begin
            r_perf_upd <= r_perf_upd + 32'd1;
            if (bus.upd_mispred) r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign bus.perf_upd_cnt     = r_perf_upd;
    assign bus.perf_mispred_cnt = r_perf_mis;
`else
    wire w_unused_mispred = bus.upd_mispred;

    assign bus.perf_upd_cnt     = 32'd0;
    assign bus.perf_mispred_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_bp_update_sched
// Description : Directed self-checking bench for bp_update_sched.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_bp_update_sched;
    localparam int IDX_W   = 6;
    localparam int ENTRIES = 64;
    localparam int DATA_W  = 2;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   busy_cycles = 0;

    bp_update_sched_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    bp_update_sched #(
        .IDX_W    (IDX_W),
        .ENTRIES  (ENTRIES),
        .DATA_W   (DATA_W),
        .INIT_VAL (2'b01),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Checks n sweep cycles starting at index 0; optionally pushes during the
    // first push_n cycles and pulses flush_req on cycle flush_at.
    task automatic do_sweep(input int n, input int push_n, input int flush_at);
        for (int i = 0; i < n; i++) begin
            check("sweep_we",    bus.tbl_we, 1);
            check("sweep_idx",   bus.tbl_widx, i);
            check("sweep_data",  bus.tbl_wdata, 2'b01);
            check("sweep_busy",  bus.busy, 1);
            check("sweep_ready", bus.upd_ready, 1);
            if (bus.busy) busy_cycles++;
            bus.upd_valid   = (i < push_n);
            bus.upd_mispred = (i < push_n);
            bus.upd_idx     = 6'd40;
            bus.upd_data    = 2'd3;
            bus.flush_req   = (i == flush_at);
            tick();
        end
        bus.upd_valid   = 1'b0;
        bus.upd_mispred = 1'b0;
        bus.flush_req   = 1'b0;
    endtask

    initial begin
        int s;
        bit acc;
        int cnt_tab [6] = '{4, 3, 3, 3, 2, 1};
        int rdy_tab [6] = '{0, 1, 1, 1, 1, 1};

        bus.upd_valid   = 1'b0;
        bus.upd_idx     = '0;
        bus.upd_data    = '0;
        bus.upd_mispred = 1'b0;
        bus.flush_req   = 1'b0;
        bus.hold        = 1'b0;

        // Reset state while rst is held
        #2;
        check("rst_busy",  bus.busy, 1);
        check("rst_we",    bus.tbl_we, 1);
        check("rst_widx",  bus.tbl_widx, 0);
        check("rst_wdata", bus.tbl_wdata, 2'b01);
        check("rst_count", bus.fifo_count, 0);
        check("rst_perf_upd", bus.perf_upd_cnt, 0);
        check("rst_perf_mis", bus.perf_mispred_cnt, 0);
        tick();
        rst = 1'b0;

        // Initial sweep: 64 cycles, then idle RUN
        do_sweep(ENTRIES, 0, -1);
        check("run_busy",  bus.busy, 0);
        check("run_we",    bus.tbl_we, 0);
        check("run_count", bus.fifo_count, 0);

        // Single update: 1-cycle accept-to-write latency
        bus.upd_valid = 1'b1; bus.upd_idx = 6'd5; bus.upd_data = 2'd3;
        check("single_ready", bus.upd_ready, 1);
        tick();
        bus.upd_valid = 1'b0;
        check("single_we",    bus.tbl_we, 1);
        check("single_widx",  bus.tbl_widx, 5);
        check("single_wdata", bus.tbl_wdata, 3);
        check("single_count", bus.fifo_count, 1);
        tick();
        check("single_done_we",    bus.tbl_we, 0);
        check("single_done_count", bus.fifo_count, 0);

        // Back-to-back 1,2,3
        for (int i = 1; i <= 3; i++) begin
            bus.upd_valid = 1'b1; bus.upd_idx = IDX_W'(i); bus.upd_data = DATA_W'(i);
            tick();
            check("b2b_we",    bus.tbl_we, 1);
            check("b2b_widx",  bus.tbl_widx, i);
            check("b2b_wdata", bus.tbl_wdata, i);
            check("b2b_count", bus.fifo_count, 1);
        end
        bus.upd_valid = 1'b0;
        tick();
        check("b2b_done_we",    bus.tbl_we, 0);
        check("b2b_done_count", bus.fifo_count, 0);

        // Hold: fill to DEPTH, then drain in order while the rest trickle in
        bus.hold = 1'b1;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            check("fill_ready", bus.upd_ready, 1);
            check("fill_count", bus.fifo_count, k);
            check("fill_we",    bus.tbl_we, 0);
            bus.upd_valid = 1'b1; bus.upd_idx = IDX_W'(10 + s); bus.upd_data = DATA_W'(s);
            tick();
            s++;
        end
        bus.upd_idx = IDX_W'(10 + s); bus.upd_data = DATA_W'(s);
        check("full_count", bus.fifo_count, 4);
        check("full_ready", bus.upd_ready, 0);
        check("full_we",    bus.tbl_we, 0);
        tick();
        check("full_hold_count", bus.fifo_count, 4);
        check("full_hold_ready", bus.upd_ready, 0);
        bus.hold = 1'b0;
        #1;
        for (int j = 0; j < 6; j++) begin
            check("drain_we",    bus.tbl_we, 1);
            check("drain_widx",  bus.tbl_widx, 10 + j);
            check("drain_wdata", bus.tbl_wdata, j % 4);
            check("drain_count", bus.fifo_count, cnt_tab[j]);
            check("drain_ready", bus.upd_ready, rdy_tab[j]);
            acc = bus.upd_valid && bus.upd_ready;
            tick();
            if (acc) s++;
            bus.upd_valid = (s < 6);
            bus.upd_idx   = IDX_W'(10 + s);
            bus.upd_data  = DATA_W'(s);
        end
        bus.upd_valid = 1'b0;
        check("drain_done_we",    bus.tbl_we, 0);
        check("drain_done_count", bus.fifo_count, 0);

        // Flush with 3 queued plus a coincident push, then re-flush mid-sweep
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1'b1; bus.upd_idx = IDX_W'(20 + k); bus.upd_data = 2'd2;
            tick();
        end
        check("preflush_count", bus.fifo_count, 3);
        bus.upd_idx = 6'd23; bus.flush_req = 1'b1;
        tick();
        bus.upd_valid = 1'b0; bus.flush_req = 1'b0;
        check("flush_count", bus.fifo_count, 0);
        busy_cycles = 0;
        do_sweep(10, 0, 9);
        bus.hold = 1'b0;
        do_sweep(ENTRIES, 0, -1);
        check("flush_busy_cycles", busy_cycles, 74);
        check("flush_end_busy",  bus.busy, 0);
        check("flush_end_we",    bus.tbl_we, 0);
        check("flush_end_count", bus.fifo_count, 0);

        // Async reset mid-drain
        bus.hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.upd_valid = 1'b1; bus.upd_idx = IDX_W'(30 + k); bus.upd_data = 2'd0;
            tick();
        end
        bus.upd_valid = 1'b0;
        check("pre_arst_count", bus.fifo_count, 2);
        check("pre_arst_busy",  bus.busy, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  bus.busy, 1);
        check("arst_we",    bus.tbl_we, 1);
        check("arst_widx",  bus.tbl_widx, 0);
        check("arst_wdata", bus.tbl_wdata, 2'b01);
        check("arst_count", bus.fifo_count, 0);
        check("arst_ready", bus.upd_ready, 1);
        tick();
        rst = 1'b0;
        bus.hold = 1'b0;
        check("arst_perf_upd", bus.perf_upd_cnt, 0);
        check("arst_perf_mis", bus.perf_mispred_cnt, 0);
        do_sweep(ENTRIES, 2, -1);
        for (int k = 0; k < 3; k++) begin
            check("no_stale_we",    bus.tbl_we, 0);
            check("no_stale_count", bus.fifo_count, 0);
            tick();
        end

        // Perf: 10 accepted updates, 3 mispredicted
        for (int i = 0; i < 10; i++) begin
            bus.upd_valid   = 1'b1;
            bus.upd_idx     = IDX_W'(50 + i);
            bus.upd_data    = DATA_W'(i);
            bus.upd_mispred = (i == 2) || (i == 5) || (i == 7);
            tick();
            check("perf_widx", bus.tbl_widx, 50 + i);
            check("perf_we",   bus.tbl_we, 1);
        end
        bus.upd_valid = 1'b0; bus.upd_mispred = 1'b0;
        tick();
        check("perf_count", bus.fifo_count, 0);
`ifdef BP_UPD_SCHED_PERF_EN
        check("perf_upd_cnt", bus.perf_upd_cnt, 10);
        check("perf_mis_cnt", bus.perf_mispred_cnt, 3);
`else
        check("perf_upd_cnt", bus.perf_upd_cnt, 0);
        check("perf_mis_cnt", bus.perf_mispred_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
